// File: rtl/snake_game_ctrl_if.sv
// Handshake bundle between the snake sequencer and its neighbours (buttons, datapath, food generator).
// master = the sequencer itself, slave = the surrounding datapath/test environment.
interface snake_game_ctrl_if #(
   parameter int NUM_LEN  = 10,
   parameter int LEN_BITS = 4
);
   logic                start;
   logic [3:0]          btn;
   logic                stop_in;
   logic [NUM_LEN-1:0]  head_pos;
   logic [NUM_LEN-1:0]  food_pos;
   logic                step;
   logic                init_load;
   logic [1:0]          di;
   logic [LEN_BITS-1:0] len;
   logic                food_req;
   logic [7:0]          score;
   logic                game_over;

   modport master (
      input  start, btn, stop_in, head_pos, food_pos,
      output step, init_load, di, len, food_req, score, game_over
   );

   modport slave (
      output start, btn, stop_in, head_pos, food_pos,
      input  step, init_load, di, len, food_req, score, game_over
   );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move pacing, direction filtering, growth/score and game-over detection.
// Optional macro SNAKE_PAUSE_EN adds a PAUSE state toggled by start while running.
module snake_game_ctrl #(
   parameter int MAX_LEN  = 16,
   parameter int NUM_LEN  = 10,
   parameter int LEN_BITS = 4,
   parameter int INIT_LEN = 3,
   parameter int TICK_DIV = 25_000_000
) (
   input logic              clk,
   input logic              rst,
   snake_game_ctrl_if.master bus
);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [LEN_BITS-1:0] LEN_INIT  = LEN_BITS'(INIT_LEN);
   localparam logic [LEN_BITS-1:0] LEN_MAX   = LEN_BITS'(MAX_LEN - 1);
   localparam logic [1:0]          DIR_R     = 2'b01;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_EVAL, S_OVER, S_PAUSE} state_t;

   state_t              state, state_nx;
   logic [TW-1:0]       tick, tick_nx;
   logic [1:0]          di, di_nx, pend_di, pend_nx;
   logic [LEN_BITS-1:0] len, len_nx;
   logic [7:0]          score, score_nx;
   logic                step, step_nx, init_load, init_nx;
   logic                food_req, food_nx, game_over, over_nx;
   logic [1:0]          cand;
   logic                cand_ok;
   logic [NUM_LEN-1:0]  head_c, food_c;

   assign head_c = bus.head_pos;
   assign food_c = bus.food_pos;

   // Lowest set button index is also its direction code; a press reversing di is dropped.
   always_comb begin
      cand = 2'b00;
      if      (bus.btn[0]) cand = 2'b00;
      else if (bus.btn[1]) cand = 2'b01;
      else if (bus.btn[2]) cand = 2'b10;
      else if (bus.btn[3]) cand = 2'b11;
      cand_ok = (|bus.btn) && (cand != (di ^ 2'b01));
`ifdef SNAKE_PAUSE_EN
      if (state == S_PAUSE) cand_ok = 1'b0;
`endif
   end

   always_comb begin
      state_nx = state;
      tick_nx  = tick;
      di_nx    = di;
      pend_nx  = cand_ok ? cand : pend_di;
      len_nx   = len;
      score_nx = score;
      step_nx  = 1'b0;
      init_nx  = 1'b0;
      food_nx  = 1'b0;
      over_nx  = game_over;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_nx = S_RUN;
               tick_nx  = '0;
               score_nx = '0;
               len_nx   = LEN_INIT;
               di_nx    = DIR_R;
               pend_nx  = DIR_R;
               init_nx  = 1'b1;
            end
         end
         S_RUN: begin
`ifdef SNAKE_PAUSE_EN
            if (bus.start) begin
               state_nx = S_PAUSE;
            end else
`endif
            if (tick == TICK_LAST) begin
               tick_nx  = '0;
               step_nx  = 1'b1;
               di_nx    = pend_di;
               state_nx = S_WAIT;
            end else begin
               tick_nx = tick + TW'(1);
            end
         end
         // Gives the datapath one cycle to register the moved head and its hit flag.
         S_WAIT: state_nx = S_EVAL;
         S_EVAL: begin
            if (bus.stop_in) begin
               state_nx = S_OVER;
               over_nx  = 1'b1;
            end else begin
               state_nx = S_RUN;
               if (head_c == food_c) begin
                  food_nx  = 1'b1;
                  score_nx = (score == 8'hFF) ? score : score + 8'd1;
                  len_nx   = (len == LEN_MAX) ? len : len + LEN_BITS'(1);
               end
            end
         end
         S_OVER: begin
            if (bus.start) begin
               state_nx = S_IDLE;
               over_nx  = 1'b0;
            end
         end
`ifdef SNAKE_PAUSE_EN
         S_PAUSE: if (bus.start) state_nx = S_RUN;
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         tick      <= '0;
         di        <= DIR_R;
         pend_di   <= DIR_R;
         len       <= LEN_INIT;
         score     <= '0;
         step      <= 1'b0;
         init_load <= 1'b0;
         food_req  <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_nx;
         tick      <= tick_nx;
         di        <= di_nx;
         pend_di   <= pend_nx;
         len       <= len_nx;
         score     <= score_nx;
         step      <= step_nx;
         init_load <= init_nx;
         food_req  <= food_nx;
         game_over <= over_nx;
      end
   end

   assign bus.step      = step;
   assign bus.init_load = init_load;
   assign bus.di        = di;
   assign bus.len       = len;
   assign bus.food_req  = food_req;
   assign bus.score     = score;
   assign bus.game_over = game_over;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios then random play, every cycle checked against a move-count model.
module tb_snake_game_ctrl;
   localparam int TICK_DIV = 4;
   localparam int INIT_LEN = 3;
   localparam int PERIOD   = TICK_DIV + 2;
   localparam int LEN_CAP  = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   snake_game_ctrl_if #(.NUM_LEN(10), .LEN_BITS(4)) bus ();

   snake_game_ctrl #(
      .MAX_LEN(16), .NUM_LEN(10), .LEN_BITS(4), .INIT_LEN(INIT_LEN), .TICK_DIV(TICK_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Model: mode 0 idle, 1 playing, 2 over; k counts edges since the start edge.
   int         mode, k, m_len, m_score;
   logic [1:0] m_di, m_pend;
   bit         e_step, e_init, e_food;

   function automatic logic [1:0] opposite(input logic [1:0] d);
      case (d)
         2'd0: return 2'd1;
         2'd1: return 2'd0;
         2'd2: return 2'd3;
         default: return 2'd2;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      logic [1:0] cand, old_pend;
      e_step = 0; e_init = 0; e_food = 0;
      if (!rst) begin
         mode = 0; m_di = 2'd1; m_pend = 2'd1; m_len = INIT_LEN; m_score = 0;
         return;
      end
      cand = 2'd0;
      for (int i = 3; i >= 0; i--) if (bus.btn[i]) cand = 2'(i);
      old_pend = m_pend;
      if (bus.btn != 4'b0 && cand != opposite(m_di)) m_pend = cand;
      case (mode)
         0: if (bus.start) begin
               mode = 1; k = 0; e_init = 1; m_len = INIT_LEN; m_score = 0;
               m_di = 2'd1; m_pend = 2'd1;
            end
         1: begin
               k++;
               if (k % PERIOD == TICK_DIV) begin
                  e_step = 1; m_di = old_pend;
               end
               if (k % PERIOD == 0) begin
                  if (bus.stop_in) mode = 2;
                  else if (bus.head_pos == bus.food_pos) begin
                     e_food  = 1;
                     m_score = (m_score < 255) ? m_score + 1 : 255;
                     m_len   = (m_len < LEN_CAP) ? m_len + 1 : LEN_CAP;
                  end
               end
            end
         default: if (bus.start) mode = 0;
      endcase
   endtask

   task automatic check_all();
      chk("step",      bus.step,      e_step);
      chk("init_load", bus.init_load, e_init);
      chk("di",        bus.di,        m_di);
      chk("len",       bus.len,       m_len);
      chk("score",     bus.score,     m_score);
      chk("food_req",  bus.food_req,  e_food);
      chk("game_over", bus.game_over, mode == 2);
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
      bus.start = 1'b0;
      bus.btn   = 4'b0;
   endtask

   task automatic run_to_step();
      int n = 0;
      do begin
         cyc();
         n++;
      end while (!e_step && n < 3 * PERIOD);
      chk("step_seen", bus.step, 1'b1);
   endtask

   initial begin
      bus.start = 0; bus.btn = 0; bus.stop_in = 0; bus.head_pos = 10'd1; bus.food_pos = 10'd2;
      rst = 1'b0;
      cyc(); cyc();
      chk("rst_di", bus.di, 2'b01);
      chk("rst_len", bus.len, 3);
      chk("rst_score", bus.score, 0);
      chk("rst_over", bus.game_over, 0);
      rst = 1'b1;
      cyc(); cyc();

      bus.start = 1'b1; cyc();
      chk("init_pulse", bus.init_load, 1'b1);
      for (int i = 0; i < 2 * PERIOD; i++) cyc();

      // left while heading right is a reversal
      bus.btn = 4'b0001; cyc();
      run_to_step();
      chk("rev_reject", bus.di, 2'b01);
      bus.btn = 4'b0100; cyc();
      run_to_step();
      chk("up_taken", bus.di, 2'b10);
      bus.btn = 4'b0001; cyc();
      run_to_step();
      chk("left_taken", bus.di, 2'b00);
      bus.btn = 4'b1100; cyc();
      run_to_step();
      chk("up_wins", bus.di, 2'b10);

      // one food hit
      bus.head_pos = 10'd37; bus.food_pos = 10'd37;
      cyc(); cyc();
      chk("food_pulse", bus.food_req, 1'b1);
      chk("food_score", bus.score, 1);
      chk("food_len", bus.len, 4);
      cyc();
      chk("food_once", bus.food_req, 1'b0);

      // grow to the cap and past it
      for (int i = 0; i < 14; i++) run_to_step();
      run_to_step(); cyc(); cyc();
      chk("len_sat", bus.len, 15);
      chk("score_cnt", bus.score, 16);
      bus.food_pos = 10'd5;

      run_to_step();
      bus.stop_in = 1'b1; cyc(); cyc();
      chk("over_set", bus.game_over, 1'b1);
      bus.stop_in = 1'b0;
      for (int i = 0; i < 3 * PERIOD; i++) cyc();
      bus.start = 1'b1; cyc();
      chk("over_clr", bus.game_over, 1'b0);
      cyc();
      bus.start = 1'b1; cyc();
      chk("restart_len", bus.len, 3);
      chk("restart_score", bus.score, 0);

      run_to_step();
      rst = 1'b0; cyc(); rst = 1'b1;
      chk("wait_rst_step", bus.step, 1'b0);
      chk("wait_rst_di", bus.di, 2'b01);

      for (int i = 0; i < 6000; i++) begin
         bus.start    = ($urandom_range(0, 40) == 0);
         bus.btn      = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
         bus.stop_in  = ($urandom_range(0, 60) == 0);
         bus.head_pos = 10'($urandom_range(0, 2));
         bus.food_pos = 10'($urandom_range(0, 2));
         rst          = ($urandom_range(0, 700) != 0);
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
